// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: MIPS execute unit with registered I-type ALU results/flags and an
// iterative multiply/divide engine writing HI/LO.
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   Start               - one-cycle request, sampled only while Busy=0
//   OPCode, Funct       - MIPS opcode and R-type function field
//   Rs, Rt, Immediate   - operands and raw immediate field
//   Result, HI, LO      - registered result and HI/LO registers
//   carryOut, Zero, overFlow, DivByZero - registered flags
//   Busy, Done          - multi-cycle handshake (Done is a one-cycle pulse)
module alu_muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IMM_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [5:0]       OPCode,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] Rs,
  input  logic [WIDTH-1:0] Rt,
  input  logic [IMM_W-1:0] Immediate,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             carryOut,
  output logic             Zero,
  output logic             overFlow,
  output logic             DivByZero,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned     CntW     = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  localparam logic [5:0] OpRtype = 6'h00, OpBeq  = 6'h04, OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08, OpAddiu = 6'h09, OpSlti = 6'h0A;
  localparam logic [5:0] OpSltiu = 6'h0B, OpAndi = 6'h0C, OpOri   = 6'h0D, OpLui = 6'h0F;
  localparam logic [5:0] FnMfhi  = 6'h10, FnMflo = 6'h12, FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19, FnDiv  = 6'h1A, FnDivu  = 6'h1B;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e            r_state;
  logic [WIDTH-1:0]  r_result, r_hi, r_lo;
  logic              r_carry, r_zero, r_ovf, r_dbz, r_done;
  logic [CntW-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_op_a;    // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]  r_acc_hi;  // partial product high half / running remainder
  logic [WIDTH-1:0]  r_acc_lo;  // multiplier bits / dividend bits becoming quotient
  logic              r_neg_q, r_neg_r, r_is_div;

  // Decode and operand preparation
  logic             w_is_r, w_is_mul, w_is_div, w_signed, w_rs_neg, w_rt_neg;
  logic [WIDTH-1:0] w_rs_mag, w_rt_mag, w_imm_sext, w_imm_zext;
  logic [WIDTH:0]   w_add;

  assign w_is_r     = (OPCode == OpRtype);
  assign w_is_mul   = w_is_r && ((Funct == FnMult) || (Funct == FnMultu));
  assign w_is_div   = w_is_r && ((Funct == FnDiv) || (Funct == FnDivu));
  assign w_signed   = ~Funct[0];  // MULT/DIV are even functs, MULTU/DIVU odd
  assign w_rs_neg   = w_signed & Rs[WIDTH-1];
  assign w_rt_neg   = w_signed & Rt[WIDTH-1];
  assign w_rs_mag   = w_rs_neg ? -Rs : Rs;
  assign w_rt_mag   = w_rt_neg ? -Rt : Rt;
  assign w_imm_sext = {{(WIDTH-IMM_W){Immediate[IMM_W-1]}}, Immediate};
  assign w_imm_zext = {{(WIDTH-IMM_W){1'b0}}, Immediate};
  assign w_add      = {1'b0, Rs} + {1'b0, w_imm_sext};

  // Single-cycle result and flags
  logic [WIDTH-1:0] w_res;
  logic             w_carry, w_ovf, w_zero, w_valid, w_branch, w_br_zero;

  always_comb begin
    w_res     = '0;
    w_carry   = 1'b0;
    w_ovf     = 1'b0;
    w_valid   = 1'b1;
    w_branch  = 1'b0;
    w_br_zero = 1'b0;
    case (OPCode)
      OpAddi: begin
        w_res   = w_add[WIDTH-1:0];
        w_carry = w_add[WIDTH];
        w_ovf   = (Rs[WIDTH-1] == w_imm_sext[WIDTH-1]) && (w_add[WIDTH-1] != Rs[WIDTH-1]);
      end
      OpAddiu: begin
        w_res   = w_add[WIDTH-1:0];
        w_carry = w_add[WIDTH];
      end
      OpAndi:  w_res = Rs & w_imm_zext;
      OpOri:   w_res = Rs | w_imm_zext;
      OpLui:   w_res = {Immediate, {(WIDTH-IMM_W){1'b0}}};
      OpSlti:  w_res = {{(WIDTH-1){1'b0}}, ($signed(Rs) < $signed(w_imm_sext))};
      OpSltiu: w_res = {{(WIDTH-1){1'b0}}, (Rs < w_imm_sext)};
      OpBeq: begin
        w_res     = Rs - Rt;
        w_branch  = 1'b1;
        w_br_zero = (Rs == Rt);
      end
      OpBne: begin
        w_res     = Rs - Rt;
        w_branch  = 1'b1;
        w_br_zero = (Rs != Rt);
      end
      OpRtype: begin
        if (Funct == FnMfhi) begin
          w_res = r_hi;
        end else if (Funct == FnMflo) begin
          w_res = r_lo;
        end else begin
          w_valid = 1'b0;
        end
      end
      default: w_valid = 1'b0;
    endcase
    w_zero = w_valid && (w_branch ? w_br_zero : (w_res == '0));
  end

  // Iteration datapath
  logic [WIDTH:0]     w_mul_sum, w_div_shift, w_div_diff;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot_fix, w_rem_fix;

  assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_op_a} : '0);
  assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_op_a};
  // Remainder stays below the divisor, so a clear top bit means no borrow
  assign w_div_ge    = ~w_div_diff[WIDTH];
  assign w_prod_fix  = r_neg_q ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
  assign w_quot_fix  = r_neg_q ? -r_acc_lo : r_acc_lo;
  assign w_rem_fix   = r_neg_r ? -r_acc_hi : r_acc_hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_result <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_dbz    <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_op_a   <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_div <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (Start) begin
            if (w_is_mul) begin
              r_state  <= StMul;
              r_op_a   <= w_rs_mag;
              r_acc_hi <= '0;
              r_acc_lo <= w_rt_mag;
              r_neg_q  <= w_rs_neg ^ w_rt_neg;
              r_neg_r  <= 1'b0;
              r_is_div <= 1'b0;
              r_cnt    <= '0;
            end else if (w_is_div && (Rt != '0)) begin
              r_state  <= StDiv;
              r_op_a   <= w_rt_mag;
              r_acc_hi <= '0;
              r_acc_lo <= w_rs_mag;
              r_neg_q  <= w_rs_neg ^ w_rt_neg;
              r_neg_r  <= w_rs_neg;
              r_is_div <= 1'b1;
              r_cnt    <= '0;
            end else if (w_is_div) begin
              r_hi   <= Rs;
              r_lo   <= '1;
              r_dbz  <= 1'b1;
              r_done <= 1'b1;
            end else begin
              r_result <= w_res;
              r_carry  <= w_carry;
              r_zero   <= w_zero;
              r_ovf    <= w_ovf;
              r_dbz    <= 1'b0;
              r_done   <= 1'b1;
            end
          end
        end
        StMul: begin
          r_acc_hi <= w_mul_sum[WIDTH:1];
          r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LastIter) r_state <= StFix;
        end
        StDiv: begin
          r_acc_hi <= w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
          r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_div_ge};
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LastIter) r_state <= StFix;
        end
        StFix: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quot_fix;
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
          end
          r_dbz   <= 1'b0;
          r_done  <= 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign Result    = r_result;
  assign HI        = r_hi;
  assign LO        = r_lo;
  assign carryOut  = r_carry;
  assign Zero      = r_zero;
  assign overFlow  = r_ovf;
  assign DivByZero = r_dbz;
  assign Busy      = (r_state != StIdle);
  assign Done      = r_done;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb_alu_muldiv_unit: random and directed stimulus for alu_muldiv_unit, checked every
// cycle against an arithmetic reference model, plus literal expectations.
module tb_alu_muldiv_unit;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Start = 1'b0;
  logic [5:0]  OPCode = '0;
  logic [5:0]  Funct = '0;
  logic [31:0] Rs = '0;
  logic [31:0] Rt = '0;
  logic [15:0] Immediate = '0;
  logic [31:0] Result, HI, LO;
  logic        carryOut, Zero, overFlow, DivByZero, Busy, Done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  alu_muldiv_unit #(.WIDTH(W), .IMM_W(16)) dut (
    .clk(clk), .reset(reset), .Start(Start), .OPCode(OPCode), .Funct(Funct),
    .Rs(Rs), .Rt(Rt), .Immediate(Immediate), .Result(Result), .HI(HI), .LO(LO),
    .carryOut(carryOut), .Zero(Zero), .overFlow(overFlow), .DivByZero(DivByZero),
    .Busy(Busy), .Done(Done)
  );

  typedef struct {
    logic [31:0] res, hi, lo, p_hi, p_lo;
    logic        carry, zero, ovf, dbz, done;
    int          cnt;  // cycles until a pending mul/div completes
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t n;
    n.res = '0; n.hi = '0; n.lo = '0; n.p_hi = '0; n.p_lo = '0;
    n.carry = 1'b0; n.zero = 1'b0; n.ovf = 1'b0; n.dbz = 1'b0; n.done = 1'b0;
    n.cnt = 0;
    return n;
  endfunction

  function automatic model_t model_step(model_t cur, logic st, logic [5:0] op, logic [5:0] fn,
                                        logic [31:0] rs, logic [31:0] rt, logic [15:0] imm);
    model_t n;
    int srs, srt, sse;
    longint sa, sp, sq, sr;
    logic [63:0] ua, up;
    logic [31:0] se;
    n = cur;
    n.done = 1'b0;
    se = {{16{imm[15]}}, imm};
    srs = rs; srt = rt; sse = se;
    if (cur.cnt > 0) begin
      n.cnt = cur.cnt - 1;
      if (n.cnt == 0) begin
        n.hi = cur.p_hi; n.lo = cur.p_lo; n.done = 1'b1; n.dbz = 1'b0;
      end
    end else if (st) begin
      if (op == 6'h00 && fn inside {6'h18, 6'h19, 6'h1A, 6'h1B}) begin
        if (fn == 6'h18) begin
          sp = longint'(srs) * longint'(srt);
          {n.p_hi, n.p_lo} = sp;
          n.cnt = W + 1;
        end else if (fn == 6'h19) begin
          up = {32'b0, rs} * {32'b0, rt};
          {n.p_hi, n.p_lo} = up;
          n.cnt = W + 1;
        end else if (rt == 0) begin
          n.hi = rs; n.lo = '1; n.dbz = 1'b1; n.done = 1'b1;
        end else if (fn == 6'h1A) begin
          sq = longint'(srs) / longint'(srt);
          sr = longint'(srs) % longint'(srt);
          n.p_lo = sq[31:0]; n.p_hi = sr[31:0];
          n.cnt = W + 1;
        end else begin
          n.p_lo = rs / rt; n.p_hi = rs % rt;
          n.cnt = W + 1;
        end
      end else begin
        n.done = 1'b1; n.dbz = 1'b0; n.carry = 1'b0; n.ovf = 1'b0; n.res = '0; n.zero = 1'b0;
        sa = longint'(srs) + longint'(sse);
        ua = {32'b0, rs} + {32'b0, se};
        case (op)
          6'h08: begin
            n.res = rs + se; n.carry = (ua > 64'hFFFF_FFFF); n.zero = (n.res == 0);
            n.ovf = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
          end
          6'h09: begin
            n.res = rs + se; n.carry = (ua > 64'hFFFF_FFFF); n.zero = (n.res == 0);
          end
          6'h0C: begin n.res = rs & {16'b0, imm}; n.zero = (n.res == 0); end
          6'h0D: begin n.res = rs | {16'b0, imm}; n.zero = (n.res == 0); end
          6'h0F: begin n.res = {imm, 16'b0}; n.zero = (n.res == 0); end
          6'h0A: begin n.res = (srs < sse) ? 1 : 0; n.zero = (n.res == 0); end
          6'h0B: begin n.res = (rs < se) ? 1 : 0; n.zero = (n.res == 0); end
          6'h04: begin n.res = rs - rt; n.zero = (rs == rt); end
          6'h05: begin n.res = rs - rt; n.zero = (rs != rt); end
          6'h00: begin
            if (fn == 6'h10) begin n.res = cur.hi; n.zero = (n.res == 0); end
            else if (fn == 6'h12) begin n.res = cur.lo; n.zero = (n.res == 0); end
          end
          default: ;
        endcase
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= model_reset();
    else       m <= model_step(m, Start, OPCode, Funct, Rs, Rt, Immediate);
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    check32("Result", Result, m.res);
    check32("HI", HI, m.hi);
    check32("LO", LO, m.lo);
    check1("carryOut", carryOut, m.carry);
    check1("Zero", Zero, m.zero);
    check1("overFlow", overFlow, m.ovf);
    check1("DivByZero", DivByZero, m.dbz);
    check1("Busy", Busy, m.cnt > 0);
    check1("Done", Done, m.done);
    if (Done === 1'b1) done_cnt++;
  end

  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] imm);
    @(negedge clk); #1;
    OPCode = op; Funct = fn; Rs = a; Rt = b; Immediate = imm; Start = 1'b1;
    @(negedge clk); #1;
    Start = 1'b0;
  endtask

  // Counts cycles with Busy high, bounded so a stuck Busy cannot hang the run
  task automatic wait_idle(output int busy_cycles);
    busy_cycles = 0;
    while (Busy && busy_cycles < 64) begin
      busy_cycles++;
      @(negedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [11:0] rnd_op();
    case ($urandom_range(0, 17))
      0: return {6'h08, 6'h00};  1: return {6'h09, 6'h00};  2: return {6'h0C, 6'h00};
      3: return {6'h0D, 6'h00};  4: return {6'h0F, 6'h00};  5: return {6'h0A, 6'h00};
      6: return {6'h0B, 6'h00};  7: return {6'h04, 6'h00};  8: return {6'h05, 6'h00};
      9: return {6'h00, 6'h10};  10: return {6'h00, 6'h12}; 11: return {6'h00, 6'h18};
      12: return {6'h00, 6'h19}; 13: return {6'h00, 6'h1A}; 14: return {6'h00, 6'h1B};
      15: return {6'h23, 6'h00}; 16: return {6'h00, 6'h20};
      default: return {6'h00, 6'h1B};
    endcase
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int done_before;
    logic [11:0] opf;

    #1 reset = 1'b1;
    @(negedge clk); #1;
    check32("reset Result", Result, 32'h0);
    check32("reset HI", HI, 32'h0);
    check32("reset LO", LO, 32'h0);
    check1("reset Busy", Busy, 1'b0);
    check1("reset Done", Done, 1'b0);
    reset = 1'b0;

    issue(6'h08, 6'h00, 32'h7FFF_FFFF, 32'h0, 16'h0001);
    check32("ADDI Result", Result, 32'h8000_0000);
    check1("ADDI overFlow", overFlow, 1'b1);
    check1("ADDI carryOut", carryOut, 1'b0);
    check1("ADDI Done", Done, 1'b1);
    check1("ADDI Busy", Busy, 1'b0);
    @(negedge clk); #1;
    check1("ADDI Done one cycle", Done, 1'b0);
    issue(6'h09, 6'h00, 32'h7FFF_FFFF, 32'h0, 16'h0001);
    check1("ADDIU overFlow", overFlow, 1'b0);
    check32("ADDIU Result", Result, 32'h8000_0000);

    issue(6'h0B, 6'h00, 32'h8000_0000, 32'h0, 16'hFFFF);
    check32("SLTIU Result", Result, 32'h1);
    issue(6'h0A, 6'h00, -32'sd6, 32'h0, 16'hFFFA);
    check32("SLTI Result", Result, 32'h0);
    issue(6'h0F, 6'h00, 32'h0, 32'h0, 16'hB512);
    check32("LUI Result", Result, 32'hB512_0000);

    issue(6'h00, 6'h18, -32'sd3, 32'd7, 16'h0);
    wait_idle(bc);
    check32("MULT busy cycles", 32'(bc), 32'd33);
    check1("MULT Done", Done, 1'b1);
    check32("MULT HI", HI, 32'hFFFF_FFFF);
    check32("MULT LO", LO, 32'hFFFF_FFEB);
    check32("model MULT LO", m.lo, 32'hFFFF_FFEB);
    check32("MULT keeps Result", Result, 32'hB512_0000);
    issue(6'h00, 6'h12, 32'h0, 32'h0, 16'h0);
    check32("MFLO Result", Result, 32'hFFFF_FFEB);

    issue(6'h00, 6'h1A, -32'sd7, 32'd2, 16'h0);
    wait_idle(bc);
    check32("DIV LO", LO, 32'hFFFF_FFFD);
    check32("DIV HI", HI, 32'hFFFF_FFFF);
    issue(6'h00, 6'h1B, 32'd100, 32'd7, 16'h0);
    wait_idle(bc);
    check32("DIVU LO", LO, 32'd14);
    check32("DIVU HI", HI, 32'd2);
    check32("model DIVU HI", m.hi, 32'd2);
    issue(6'h00, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 16'h0);
    wait_idle(bc);
    check32("DIV minneg LO", LO, 32'h8000_0000);
    check32("DIV minneg HI", HI, 32'h0);
    check1("DIV minneg flag", DivByZero, 1'b0);

    issue(6'h00, 6'h1B, 32'h1234, 32'h0, 16'h0);
    check1("DIV0 Done", Done, 1'b1);
    check1("DIV0 Busy", Busy, 1'b0);
    check1("DIV0 DivByZero", DivByZero, 1'b1);
    check32("DIV0 LO", LO, 32'hFFFF_FFFF);
    check32("DIV0 HI", HI, 32'h1234);
    issue(6'h08, 6'h00, 32'd1, 32'h0, 16'h0001);
    check1("ADDI clears DivByZero", DivByZero, 1'b0);

    // Abort: MULTU in flight, ignored BEQ, then reset
    done_before = done_cnt;
    issue(6'h00, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h0);
    repeat (3) begin @(negedge clk); #1; end
    OPCode = 6'h04; Funct = 6'h00; Rs = 32'd5; Rt = 32'd5; Start = 1'b1;
    @(negedge clk); #1;
    Start = 1'b0;
    check32("BEQ while busy ignored", Result, 32'd2);
    check32("done count while busy", 32'(done_cnt - done_before), 32'd0);
    repeat (4) begin @(negedge clk); #1; end
    reset = 1'b1;
    @(negedge clk); #1;
    check32("abort Result", Result, 32'h0);
    check32("abort HI", HI, 32'h0);
    check32("abort LO", LO, 32'h0);
    check1("abort Busy", Busy, 1'b0);
    reset = 1'b0;
    repeat (40) begin @(negedge clk); #1; end
    check32("no Done after abort", 32'(done_cnt - done_before), 32'd0);
    check32("HI stays 0 after abort", HI, 32'h0);
    issue(6'h05, 6'h00, 32'd14, 32'd1045747, 16'h0);
    check1("BNE Zero", Zero, 1'b1);
    check32("BNE Result", Result, 32'd14 - 32'd1045747);

    // Random traffic, including Start while busy and occasional reset
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      opf = rnd_op();
      OPCode = opf[11:6];
      Funct = opf[5:0];
      Rs = rnd_operand();
      Rt = ($urandom_range(0, 7) == 0) ? Rs : rnd_operand();
      Immediate = 16'($urandom);
      Start = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 249) == 0);
    end
    @(negedge clk); #1;
    Start = 1'b0;
    reset = 1'b0;
    repeat (40) begin @(negedge clk); #1; end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_unit.md
Name: alu_muldiv_unit

Overview:
Next-generation MIPS execute unit replacing the purely combinational I-type ALU.
- Width is parameterised.
- Every result and flag is registered.
- Adds iterative MULT/MULTU/DIV/DIVU with HI/LO registers, plus MFHI/MFLO read-back.
- A Start/Busy/Done handshake connects it to the multi-cycle datapath controller.

Parameters:
WIDTH, 32, datapath width; even, >= 32.
IMM_W, 16, immediate field width; fixed at 16 for MIPS encoding.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all state
Start  input  1  one-cycle request; sampled only when Busy=0
OPCode  input  6  MIPS opcode
Funct  input  6  function field, used when OPCode=000000
Rs  input  WIDTH  first operand
Rt  input  WIDTH  second operand
Immediate  input  IMM_W  raw immediate field
Result  output  WIDTH  registered ALU / MFHI / MFLO result
HI  output  WIDTH  HI register
LO  output  WIDTH  LO register
carryOut  output  1  carry out of MSB (ADDI/ADDIU)
Zero  output  1  branch-taken for BEQ/BNE, else Result==0
overFlow  output  1  signed overflow (ADDI only)
DivByZero  output  1  last DIV/DIVU had Rt==0
Busy  output  1  operation in progress
Done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, any time):
  - Outputs, HI, LO and flags go to 0; state goes to IDLE.
  - An operation in flight is aborted: no Done, HI/LO stay 0.
- Immediate extension:
  - Sign-extended to WIDTH for ADDI, ADDIU, SLTI, SLTIU.
  - Zero-extended for ANDI, ORI.
  - LUI: Result = Immediate in bits [WIDTH-1:WIDTH-16], lower bits 0.
- Single-cycle ops (ADDI 001000, ADDIU 001001, ANDI 001100, ORI 001101, LUI 001111, SLTI 001010, SLTIU 001011, BEQ 000100, BNE 000101, MFHI funct 010000, MFLO funct 010010):
  - Start in IDLE: Result and flags are written at the next edge; Done=1 for exactly one cycle; Busy stays 0.
  - SLTI compares signed; SLTIU compares unsigned (sign-extended immediate). Result is 1 or 0.
  - ADDIU never sets overFlow.
  - BEQ/BNE: Result = Rs-Rt. Zero = (Rs==Rt) for BEQ, (Rs!=Rt) for BNE.
- Unsupported opcode/funct: Result=0, all flags 0, Done pulses after 1 cycle.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL on MULT (funct 011000) / MULTU (011001).
  - IDLE -> DIV on DIV (011010) / DIVU (011011) when Rt != 0.
  - MUL/DIV: one iteration per cycle for WIDTH cycles (shift-add / restoring divide on operand magnitudes), then go to FIX.
  - FIX: applies sign correction, writes HI/LO, pulses Done, returns to IDLE.
- Mul/div latency and handshake:
  - Busy rises at the Start edge.
  - HI/LO are written, Busy falls and Done rises at edge WIDTH+1 after the Start edge.
- Multiply: {HI,LO} = full 2*WIDTH-bit product. Signed for MULT, unsigned for MULTU.
- Divide:
  - LO = quotient, truncated toward zero.
  - HI = remainder, taking the sign of the dividend.
  - Most-negative / -1 gives LO = most-negative, HI = 0, no flag.
- Divide by zero: 1-cycle latency. LO = all ones, HI = Rs, DivByZero=1. No transition to DIV.
- DivByZero: cleared by the next Done of any other operation.
- Flags and Result hold their values until the next Done.
- MULT/DIV leave Result unchanged.
- Start while Busy=1 is ignored; no queuing.
- Start with Busy=0 in the Done cycle is accepted.
- Operands (Rs, Rt) are latched at the Start edge; later input changes have no effect.

Test Plan:
- ADDI Rs=32'h7FFFFFFF, Imm=16'h0001 -> next edge Result=32'h80000000, overFlow=1, carryOut=0, Done 1 cycle; ADDIU with same operands -> overFlow=0.
- SLTIU Rs=32'h80000000, Imm=16'hFFFF -> Result=1; SLTI Rs=-6, Imm=16'hFFFA -> Result=0; LUI Imm=16'hB512 -> Result=32'hB5120000.
- MULT Rs=-3, Rt=7 -> Busy 33 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFEB, Done 1 cycle; following MFLO -> Result=32'hFFFFFFEB.
- DIV Rs=-7, Rt=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; DIVU Rs=100, Rt=7 -> LO=14, HI=2.
- DIVU Rs=32'h1234, Rt=0 -> Done after 1 cycle, DivByZero=1, LO=32'hFFFFFFFF, HI=32'h1234; next ADDI clears DivByZero.
- MULTU started; Start with BEQ at cycle 5 -> ignored; reset pulsed at cycle 10 -> all outputs 0, no Done; subsequent BNE Rs=14, Rt=1045747 -> Zero=1.
